// File: rtl/spi_slave_if_if.sv
// SPI pin and controller-side byte bundle for the spi_slave_if front end.
// Optional miso_oe member exists only when SPI_SLAVE_MISO_HIZ_EN is defined.
interface spi_slave_if_if #(
    parameter int BYTE_BITS = 8
) ();
    logic                 sck;
    logic                 cs_n;
    logic                 mosi;
    logic                 miso;
    logic [BYTE_BITS-1:0] tx_byte;
    logic [BYTE_BITS-1:0] rx_byte;
    logic                 cycle_done;
`ifdef SPI_SLAVE_MISO_HIZ_EN
    logic                 miso_oe;
`endif

    // Handshake: cycle_done is a 1-clk strobe, rx_byte is valid and stable with it;
    // there is no ready/backpressure, the controller must accept every strobe.
    modport slave (
        input  sck, cs_n, mosi, tx_byte,
`ifdef SPI_SLAVE_MISO_HIZ_EN
        output miso_oe,
`endif
        output miso, rx_byte, cycle_done
    );

    modport master (
        output sck, cs_n, mosi, tx_byte,
`ifdef SPI_SLAVE_MISO_HIZ_EN
        input  miso_oe,
`endif
        input  miso, rx_byte, cycle_done
    );
endinterface

// File: rtl/spi_slave_if.sv
// SPI mode-0 slave front end: pin synchronisers, MOSI deserialiser, MISO serialiser.
// Define SPI_SLAVE_MISO_HIZ_EN to add the miso_oe pad enable.
module spi_slave_if #(
    parameter int SYNC_STAGES = 2,
    parameter int BYTE_BITS   = 8
) (
    input  logic           clk,
    input  logic           rst,
    spi_slave_if_if.slave  bus,
    output logic           o_dbg_state
);
    localparam int CW = (BYTE_BITS > 1) ? $clog2(BYTE_BITS) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(BYTE_BITS - 1);

    typedef enum logic {
        S_IDLE   = 1'b0,
        S_ACTIVE = 1'b1
    } state_t;

    logic [SYNC_STAGES-1:0] r_sck_sync;
    logic [SYNC_STAGES-1:0] r_cs_sync;
    logic [SYNC_STAGES-1:0] r_mosi_sync;
    logic                   r_sck_d;
    logic                   r_cs_d;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [CW-1:0]          r_cnt;
    logic [CW-1:0]          w_cnt_nxt;
    logic [BYTE_BITS-1:0]   r_rx_sh;
    logic [BYTE_BITS-1:0]   w_rx_sh_nxt;
    logic [BYTE_BITS-1:0]   r_tx_sh;
    logic [BYTE_BITS-1:0]   w_tx_sh_nxt;
    logic [BYTE_BITS-1:0]   r_rx_byte;
    logic [BYTE_BITS-1:0]   w_rx_byte_nxt;
    logic                   r_done;
    logic                   w_done_nxt;

    logic                   w_sck_s;
    logic                   w_cs_s;
    logic                   w_mosi_s;
    logic                   w_sck_rise;
    logic                   w_sck_fall;
    logic                   w_cs_rise;
    logic                   w_cs_fall;
    logic [BYTE_BITS-1:0]   w_rx_shifted;

    // mosi shares the sck depth so the sampled bit lines up with the detected edge
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sck_sync  <= '0;
            r_cs_sync   <= '1;
            r_mosi_sync <= '0;
            r_sck_d     <= 1'b0;
            r_cs_d      <= 1'b1;
        end else begin
            r_sck_sync  <= {r_sck_sync[SYNC_STAGES-2:0], bus.sck};
            r_cs_sync   <= {r_cs_sync[SYNC_STAGES-2:0], bus.cs_n};
            r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], bus.mosi};
            r_sck_d     <= w_sck_s;
            r_cs_d      <= w_cs_s;
        end
    end

    assign w_sck_s      = r_sck_sync[SYNC_STAGES-1];
    assign w_cs_s       = r_cs_sync[SYNC_STAGES-1];
    assign w_mosi_s     = r_mosi_sync[SYNC_STAGES-1];
    assign w_sck_rise   = w_sck_s & ~r_sck_d;
    assign w_sck_fall   = ~w_sck_s & r_sck_d;
    assign w_cs_fall    = ~w_cs_s & r_cs_d;
    assign w_cs_rise    = w_cs_s & ~r_cs_d;
    assign w_rx_shifted = {r_rx_sh[BYTE_BITS-2:0], w_mosi_s};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_rx_sh   <= '0;
            r_tx_sh   <= '0;
            r_rx_byte <= '0;
            r_done    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_rx_sh   <= w_rx_sh_nxt;
            r_tx_sh   <= w_tx_sh_nxt;
            r_rx_byte <= w_rx_byte_nxt;
            r_done    <= w_done_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_rx_sh_nxt   = r_rx_sh;
        w_tx_sh_nxt   = r_tx_sh;
        w_rx_byte_nxt = r_rx_byte;
        w_done_nxt    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_cs_fall) begin
                    w_state_nxt = S_ACTIVE;
                    w_tx_sh_nxt = bus.tx_byte;
                    w_cnt_nxt   = '0;
                    w_rx_sh_nxt = '0;
                end
            end
            S_ACTIVE: begin
                // deselect takes priority so a coincident sck edge cannot complete a byte
                if (w_cs_rise) begin
                    w_state_nxt = S_IDLE;
                    w_cnt_nxt   = '0;
                end else if (w_sck_rise) begin
                    w_rx_sh_nxt = w_rx_shifted;
                    if (r_cnt == LAST_BIT) begin
                        w_rx_byte_nxt = w_rx_shifted;
                        w_done_nxt    = 1'b1;
                        w_cnt_nxt     = '0;
                    end else begin
                        w_cnt_nxt = r_cnt + CW'(1);
                    end
                end else if (w_sck_fall) begin
                    // counter back at 0 on a falling edge means a byte boundary: fetch the reply
                    if (r_cnt != '0) begin
                        w_tx_sh_nxt = {r_tx_sh[BYTE_BITS-2:0], 1'b0};
                    end else begin
                        w_tx_sh_nxt = bus.tx_byte;
                    end
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    assign bus.miso       = (r_state == S_ACTIVE) ? r_tx_sh[BYTE_BITS-1] : 1'b0;
    assign bus.rx_byte    = r_rx_byte;
    assign bus.cycle_done = r_done;
    assign o_dbg_state    = r_state;

`ifdef SPI_SLAVE_MISO_HIZ_EN
    assign bus.miso_oe = ~w_cs_s;
`endif

endmodule

// File: tb/tb_spi_slave_if.sv
// Randomised bench for spi_slave_if: an SPI master driver plus a byte-level scoreboard.
// Also exercises the SPI_SLAVE_MISO_HIZ_EN build when that macro is defined.
module tb_spi_slave_if;
  localparam int SYNC   = 2;
  localparam int BB     = 8;
  localparam int CLK_NS = 10;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic dbg_state;
  always #5 clk = ~clk;

  spi_slave_if_if #(.BYTE_BITS(BB)) bus ();

  spi_slave_if #(
    .SYNC_STAGES(SYNC),
    .BYTE_BITS  (BB)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .o_dbg_state(dbg_state)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // scoreboard state
  logic [BB-1:0] exp_q[$];
  logic [BB-1:0] fr_mosi[0:15];
  logic [BB-1:0] fr_tx[0:15];
  logic [BB-1:0] obs_mem[0:1023];
  logic [BB-1:0] model_last_rx = '0;
  int            pulses        = 0;
  int            frame_base    = 0;
  int            tx_idx;
  time           t_last_rise   = 0;
  logic          prev_done     = 1'b0;
  logic [BB-1:0] last_rx       = '0;

  // controller model: presents the reply for the next slot once the previous byte completes
  assign tx_idx      = pulses - frame_base;
  assign bus.tx_byte = fr_tx[tx_idx[3:0]];

  // monitor
  always @(negedge clk) begin
    if (!rst) begin
      prev_done = 1'b0;
      last_rx   = '0;
    end else begin
      if (bus.cycle_done) begin
        check_eq("done_width", prev_done, 1'b0);
        check_eq("latency_ok", ($time - t_last_rise) <= (SYNC + 2) * CLK_NS, 1'b1);
        obs_mem[pulses[9:0]] = bus.rx_byte;
        pulses++;
      end else begin
        check_eq("rx_stable", bus.rx_byte, last_rx);
      end
      last_rx   = bus.rx_byte;
      prev_done = bus.cycle_done;
    end
  end

  // driver tasks
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic xfer_bits(input logic [BB-1:0] b, input int nbits, input int half,
                           output logic [BB-1:0] got);
    got = '0;
    for (int i = BB - 1; i >= BB - nbits; i--) begin
      bus.mosi = b[i];
      tick(half);
      bus.sck = 1'b1;
      if (i == 0) t_last_rise = $time;
      got[i] = bus.miso;
      tick(half);
      bus.sck = 1'b0;
    end
  endtask

  task automatic run_frame(input int nbytes, input int half);
    logic [BB-1:0] got;
    frame_base = pulses;
    for (int k = 0; k < nbytes; k++) exp_q.push_back(fr_mosi[k]);
`ifdef SPI_SLAVE_MISO_HIZ_EN
    check_eq("oe_idle", bus.miso_oe, 1'b0);
`endif
    bus.cs_n = 1'b0;
`ifdef SPI_SLAVE_MISO_HIZ_EN
    tick(SYNC + 1);
    check_eq("oe_active", bus.miso_oe, 1'b1);
    tick(half - SYNC - 1);
`else
    tick(half);
`endif
    for (int k = 0; k < nbytes; k++) begin
      xfer_bits(fr_mosi[k], BB, half, got);
      check_eq("miso_byte", got, fr_tx[k]);
    end
    tick(half);
    bus.cs_n = 1'b1;
    tick(2 * SYNC + 4);
    check_eq("pulse_count", pulses - frame_base, nbytes);
    for (int k = 0; k < nbytes; k++) begin
      check_eq("rx_byte", obs_mem[frame_base + k], exp_q.pop_front());
    end
    model_last_rx = fr_mosi[nbytes - 1];
    check_eq("rx_hold", bus.rx_byte, model_last_rx);
    check_eq("miso_idle", bus.miso, 1'b0);
    check_eq("state_idle", dbg_state, 1'b0);
  endtask

  initial begin
    logic [BB-1:0] got;
    int nb;
    int half;
    for (int k = 0; k < 16; k++) begin
      fr_mosi[k] = '0;
      fr_tx[k]   = '0;
    end
    bus.sck  = 1'b0;
    bus.cs_n = 1'b1;
    bus.mosi = 1'b0;

    // reset state
    tick(3);
    check_eq("rst_rx_byte", bus.rx_byte, 8'h00);
    check_eq("rst_done", bus.cycle_done, 1'b0);
    check_eq("rst_miso", bus.miso, 1'b0);
    check_eq("rst_state", dbg_state, 1'b0);
`ifdef SPI_SLAVE_MISO_HIZ_EN
    check_eq("rst_oe", bus.miso_oe, 1'b0);
`endif
    rst = 1'b1;
    tick(3);

    // sck activity while deselected must be ignored
    frame_base = pulses;
    repeat (4) begin
      bus.sck = 1'b1;
      tick(6);
      bus.sck = 1'b0;
      tick(6);
    end
    check_eq("idle_sck_no_pulse", pulses - frame_base, 0);
    check_eq("idle_sck_state", dbg_state, 1'b0);

    // single byte at f_clk/16
    fr_mosi[0] = 8'hA5; fr_tx[0] = 8'h5A;
    run_frame(1, 8);

    // aborted byte: five bits of 0xFF then deselect
    frame_base = pulses;
    fr_tx[0] = 8'h00;
    bus.cs_n = 1'b0;
    tick(8);
    xfer_bits(8'hFF, 5, 8, got);
    tick(8);
    bus.cs_n = 1'b1;
    tick(10);
    check_eq("abort_no_pulse", pulses - frame_base, 0);
    check_eq("abort_rx_hold", bus.rx_byte, model_last_rx);

    fr_mosi[0] = 8'h12; fr_tx[0] = 8'h99;
    run_frame(1, 8);

    // command sequence in one frame
    fr_mosi[0] = 8'h04; fr_mosi[1] = 8'h00; fr_mosi[2] = 8'h02;
    fr_mosi[3] = 8'h00; fr_mosi[4] = 8'h03;
    for (int k = 0; k < 5; k++) fr_tx[k] = 8'($urandom);
    run_frame(5, 8);

    // transmit path: 0x3C then 0xC3
    fr_mosi[0] = 8'($urandom); fr_mosi[1] = 8'($urandom);
    fr_tx[0] = 8'h3C; fr_tx[1] = 8'hC3;
    run_frame(2, 8);

    // reset mid-byte
    fr_tx[0] = 8'h00;
    frame_base = pulses;
    bus.cs_n = 1'b0;
    tick(8);
    xfer_bits(8'hE7, 3, 8, got);
    rst = 1'b0;
    tick(1);
    check_eq("mid_rst_miso", bus.miso, 1'b0);
    check_eq("mid_rst_rx_byte", bus.rx_byte, 8'h00);
    check_eq("mid_rst_done", bus.cycle_done, 1'b0);
    check_eq("mid_rst_state", dbg_state, 1'b0);
`ifdef SPI_SLAVE_MISO_HIZ_EN
    check_eq("mid_rst_oe", bus.miso_oe, 1'b0);
`endif
    bus.cs_n = 1'b1;
    bus.sck  = 1'b0;
    bus.mosi = 1'b0;
    tick(3);
    rst = 1'b1;
    tick(4);
    model_last_rx = '0;
    check_eq("post_rst_rx_byte", bus.rx_byte, model_last_rx);
    fr_mosi[0] = 8'h81; fr_tx[0] = 8'h7E;
    run_frame(1, 8);

    // randomised frames across the supported sck rates
    repeat (20) begin
      nb   = $urandom_range(1, 5);
      half = $urandom_range(5, 10);
      for (int k = 0; k < nb; k++) begin
        fr_mosi[k] = 8'($urandom);
        fr_tx[k]   = 8'($urandom);
      end
      run_frame(nb, half);
    end

    // final report
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
